// File: rtl/qerv_rf_ram_clr.sv
// Register-file RAM with a post-reset zero-fill sweep. The array takes one write and one read per cycle, and read data is registered with 1-cycle latency.
// There is no handshake: o_busy marks the sweep, and requests that arrive during the sweep are dropped.
module qerv_rf_ram_clr #(
    parameter int    width    = 8,
    parameter int    csr_regs = 4,
    parameter int    depth    = (32 + csr_regs) * 32 / width,
    parameter int    aw       = $clog2(depth),
    parameter string rdw_mode = "WRITE_FIRST",
    parameter int    clear_en = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_busy,
    output logic             o_clr_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam int            last_i     = depth - 1;
    localparam logic [aw:0]   depth_w    = depth[aw:0];
    localparam logic [aw-1:0] last_addr  = last_i[aw-1:0];
    localparam bit            write_first = (rdw_mode == "WRITE_FIRST");

    logic [width-1:0] mem [depth];

    state_t           state_q, state_d;
    logic [aw-1:0]    clr_cnt_q, clr_cnt_d;
    logic             clr_done_q, clr_done_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic             mem_we;
    logic [aw-1:0]    mem_wa;
    logic [width-1:0] mem_wd;
    logic             wr_ok, rd_ok;

    assign wr_ok = ({1'b0, i_waddr} < depth_w);
    assign rd_ok = ({1'b0, i_raddr} < depth_w);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        rdata_d    = rdata_q;
        mem_we     = 1'b0;
        mem_wa     = i_waddr;
        mem_wd     = i_wdata;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wa    = clr_cnt_q;
                mem_wd    = '0;
                rdata_d   = '0;
                clr_cnt_d = clr_cnt_q + aw'(1);
                if (clr_cnt_q == last_addr) begin
                    state_d    = RUN;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end
            end
            RUN: begin
                mem_we = i_wen && wr_ok;
                if (i_ren) begin
                    if (!rd_ok)
                        rdata_d = '0;
                    // Bypass only matters when the write actually lands in the array.
                    else if (write_first && i_wen && (i_waddr == i_raddr))
                        rdata_d = i_wdata;
                    else
                        rdata_d = mem[i_raddr];
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= (clear_en != 0) ? CLEAR : RUN;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign o_rdata    = rdata_q;
    assign o_busy     = (state_q == CLEAR);
    assign o_clr_done = clr_done_q;

endmodule

// File: tb/tb_qerv_rf_ram_clr.sv
// Directed bench for qerv_rf_ram_clr at default parameters (depth 144, WRITE_FIRST).
module tb_qerv_rf_ram_clr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] waddr, raddr, wdata;
    logic       wen, ren;
    logic [7:0] rdata;
    logic       busy, clr_done;

    int errors = 0;
    int checks = 0;

    qerv_rf_ram_clr dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .i_wen      (wen),
        .i_raddr    (raddr),
        .i_ren      (ren),
        .o_rdata    (rdata),
        .o_busy     (busy),
        .o_clr_done (clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Caller has just released reset; counts busy/done over a bounded window.
    // When poke is set, a write of 0xFF to address 20 and a read are held during the sweep.
    task automatic sweep(input string tag, input bit poke);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int rd_nz    = 0;
        if (poke) begin
            wen = 1'b1; waddr = 8'd20; wdata = 8'hFF;
            ren = 1'b1; raddr = 8'd5;
        end
        for (int i = 0; i < 170; i++) begin
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (busy && rdata != 8'h00) rd_nz++;
            if (!busy) begin
                wen = 1'b0;
                ren = 1'b0;
            end
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cnt, 144);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, 144);
        if (poke) check({tag, "_rdata_zero_in_clear"}, rd_nz, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
        check(tag, rdata, exp);
    endtask

    initial begin
        int nz;
        rst = 1'b1; wen = 1'b1; ren = 1'b1;
        waddr = 8'd9; raddr = 8'd9; wdata = 8'hEE;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_done", clr_done, 0);
        check("rst_rdata", rdata, 8'h00);

        wen = 1'b0; ren = 1'b0;
        rst = 1'b0;
        sweep("sweep1", 1'b1);

        nz = 0;
        for (int a = 0; a < 144; a++) begin
            ren = 1'b1; raddr = 8'(a);
            tick();
            if (rdata !== 8'h00) nz++;
        end
        ren = 1'b0;
        check("all_zero_after_clear", nz, 0);
        rd("addr20_untouched", 8'd20, 8'h00);

        wr(8'd7, 8'hA5);
        rd("rd7", 8'd7, 8'hA5);
        raddr = 8'd0;
        tick(); tick();
        check("rd7_hold", rdata, 8'hA5);

        wr(8'd3, 8'h11);
        wen = 1'b1; waddr = 8'd3; wdata = 8'h3C;
        ren = 1'b1; raddr = 8'd3;
        tick();
        wen = 1'b0;
        check("rdw_same_addr", rdata, 8'h3C);
        tick();
        ren = 1'b0;
        check("rdw_followup", rdata, 8'h3C);

        wen = 1'b1; waddr = 8'd10; wdata = 8'h5A;
        ren = 1'b1; raddr = 8'd7;
        tick();
        wen = 1'b0; ren = 1'b0;
        check("diff_addr_read", rdata, 8'hA5);
        rd("diff_addr_write", 8'd10, 8'h5A);

        wr(8'd143, 8'h99);
        rd("last_word", 8'd143, 8'h99);

        wr(8'd200, 8'h77);
        rd("oor_read", 8'd200, 8'h00);
        rd("oor_alias56", 8'd56, 8'h00);
        rd("oor_keep7", 8'd7, 8'hA5);
        rd("oor_keep143", 8'd143, 8'h99);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy || clr_done) begin
                check("pre_abort_busy", {busy, clr_done}, 2'b10);
                break;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        check("abort_rst_busy", busy, 1);
        check("abort_rst_done", clr_done, 0);
        rst = 1'b0;
        sweep("sweep2", 1'b0);
        rd("recleared7", 8'd7, 8'h00);
        rd("recleared143", 8'd143, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
